// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the multi-domain reset release sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK   = 3'd0,
    LOCK_STABLE = 3'd1,
    RELEASE     = 3'd2,
    WAIT_ACK    = 3'd3,
    DELAY       = 3'd4,
    RUN         = 3'd5,
    HOLD        = 3'd6,
    FAULT       = 3'd7
  } state_t;

  localparam int unsigned HZ_PER_MHZ = 1000000;

  // Whole microseconds to sys_clk cycles, never less than one cycle.
  function automatic logic [31:0] us_to_cyc(input int unsigned freq_hz,
                                            input int unsigned us);
    logic [31:0] cyc;
    cyc = (freq_hz / HZ_PER_MHZ) * us;
    return (cyc == 32'd0) ? 32'd1 : cyc;
  endfunction

endpackage

// File: rtl/rst_seq_sync2.sv
// Two-flop synchronizer bringing the MMCM lock indication into sys_clk.
module rst_seq_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta;
  (* ASYNC_REG = "TRUE" *) logic sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Ordered reset release sequencer: releases stage resets one at a time after
// lock is stable, waits for each ack plus a guard delay, and retries on failure.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ  = 200000000,
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned LOCK_STABLE_US = 100,
  parameter int unsigned STAGE_DELAY_US = 10,
  parameter int unsigned ACK_TIMEOUT_US = 1000,
  parameter int unsigned HOLD_US        = 10,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  clock_locked,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_ready,
  output logic                  seq_fault,
  output logic [3:0]            retry_cnt,
  output logic [2:0]            debug_state
);

  localparam logic [31:0] LOCK_CYC  = us_to_cyc(CLOCK_FREQ_HZ, LOCK_STABLE_US);
  localparam logic [31:0] DELAY_CYC = us_to_cyc(CLOCK_FREQ_HZ, STAGE_DELAY_US);
  localparam logic [31:0] TMO_CYC   = us_to_cyc(CLOCK_FREQ_HZ, ACK_TIMEOUT_US);
  localparam logic [31:0] HOLD_CYC  = us_to_cyc(CLOCK_FREQ_HZ, HOLD_US);

  localparam int unsigned      IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [3:0]       MAX_R    = 4'(MAX_RETRY);
  localparam logic [NUM_STAGES-1:0] ALL_RST = '1;

  logic                  locked_s;
  state_t                state, state_nxt;
  logic [31:0]           cnt, cnt_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [3:0]            retry_nxt, retry_inc;
  logic [NUM_STAGES-1:0] rst_nxt;
  logic                  fail;
  logic                  enter;
  logic                  lock_abort;

  rst_seq_sync2 u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (clock_locked),
    .q     (locked_s)
  );

  assign retry_inc  = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
  assign lock_abort = !locked_s && (state != WAIT_LOCK) && (state != FAULT);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry_cnt;
    rst_nxt   = stage_rst;
    fail      = 1'b0;
    enter     = 1'b0;

    case (state)
      WAIT_LOCK: begin
        rst_nxt = ALL_RST;
        if (locked_s) begin
          state_nxt = LOCK_STABLE;
          enter     = 1'b1;
        end
      end
      LOCK_STABLE: begin
        if (cnt >= LOCK_CYC - 32'd1) begin
          state_nxt = RELEASE;
          idx_nxt   = '0;
          enter     = 1'b1;
        end
      end
      RELEASE: begin
        rst_nxt[idx] = 1'b0;
        state_nxt    = WAIT_ACK;
        enter        = 1'b1;
      end
      WAIT_ACK: begin
        // A timeout on the same cycle as the ack still counts as a failure.
        if (cnt >= TMO_CYC - 32'd1) begin
          fail = 1'b1;
        end else if (stage_ack[idx]) begin
          enter = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = RUN;
            retry_nxt = 4'd0;
          end else begin
            state_nxt = DELAY;
          end
        end
      end
      DELAY: begin
        if (cnt >= DELAY_CYC - 32'd1) begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = RELEASE;
          enter     = 1'b1;
        end
      end
      RUN: begin
        if (!(&stage_ack)) fail = 1'b1;
      end
      HOLD: begin
        rst_nxt = ALL_RST;
        if (cnt >= HOLD_CYC - 32'd1) begin
          state_nxt = WAIT_LOCK;
          enter     = 1'b1;
        end
      end
      FAULT: begin
        rst_nxt = ALL_RST;
      end
      default: begin
        rst_nxt   = ALL_RST;
        state_nxt = WAIT_LOCK;
        enter     = 1'b1;
      end
    endcase

    // Abort paths in rising priority order; later assignments win.
    if (fail) begin
      rst_nxt   = ALL_RST;
      retry_nxt = retry_inc;
      state_nxt = (retry_inc >= MAX_R) ? FAULT : HOLD;
      enter     = 1'b1;
    end
    if (soft_rst_req) begin
      rst_nxt   = ALL_RST;
      retry_nxt = 4'd0;
      state_nxt = HOLD;
      enter     = 1'b1;
    end
    if (lock_abort) begin
      rst_nxt   = ALL_RST;
      retry_nxt = retry_cnt;
      state_nxt = WAIT_LOCK;
      enter     = 1'b1;
    end

    if (enter || (state_nxt == WAIT_LOCK)) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = (cnt == '1) ? cnt : cnt + 32'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      idx       <= '0;
      retry_cnt <= 4'd0;
      stage_rst <= ALL_RST;
      all_ready <= 1'b0;
      seq_fault <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      retry_cnt <= retry_nxt;
      stage_rst <= rst_nxt;
      all_ready <= (state_nxt == RUN);
      seq_fault <= (state_nxt == FAULT);
    end
  end

  assign debug_state = state;

`ifndef SYNTHESIS
  logic [NUM_STAGES-1:0] released;
  assign released = ~stage_rst;

  // Released stages always form a contiguous block starting at bit 0.
  a_thermometer: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    (released & (released + NUM_STAGES'(1))) == '0);
  a_ready_clear: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    all_ready |-> (stage_rst == '0));
  a_fault_held: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    seq_fault |-> (stage_rst == ALL_RST));
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with 1 cycle per us timing constants.
module tb_rst_seq_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       clock_locked;
  logic       soft_rst_req;
  logic [2:0] stage_ack;
  logic [2:0] stage_rst;
  logic       all_ready;
  logic       seq_fault;
  logic [3:0] retry_cnt;
  logic [2:0] debug_state;

  int n_checks = 0;
  int n_fail   = 0;

  rst_seq_ctrl #(
    .CLOCK_FREQ_HZ  (1000000),
    .NUM_STAGES     (3),
    .LOCK_STABLE_US (8),
    .STAGE_DELAY_US (4),
    .ACK_TIMEOUT_US (20),
    .HOLD_US        (4),
    .MAX_RETRY      (2)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .clock_locked (clock_locked),
    .soft_rst_req (soft_rst_req),
    .stage_ack    (stage_ack),
    .stage_rst    (stage_rst),
    .all_ready    (all_ready),
    .seq_fault    (seq_fault),
    .retry_cnt    (retry_cnt),
    .debug_state  (debug_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Edges until stage_rst shows want; 64 means it never did.
  task automatic wait_rst(input logic [2:0] want, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (stage_rst !== want && n < 64);
  endtask

  // From lock (or re-entry) to RUN with each ack three cycles after its release.
  task automatic seq_nominal(input int first_lat, input string tag);
    int n;
    wait_rst(3'b110, n);
    check_val({tag, "_rel0_lat"}, n, first_lat);
    repeat (3) tick();
    stage_ack = 3'b001;
    wait_rst(3'b100, n);
    check_val({tag, "_rel1_lat"}, n, 6);
    repeat (3) tick();
    stage_ack = 3'b011;
    wait_rst(3'b000, n);
    check_val({tag, "_rel2_lat"}, n, 6);
    repeat (3) tick();
    stage_ack = 3'b111;
    tick();
    check_val({tag, "_all_ready"}, all_ready, 1);
    check_val({tag, "_state_run"}, debug_state, 5);
    check_val({tag, "_retry"}, retry_cnt, 0);
    check_val({tag, "_fault"}, seq_fault, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    sys_rst_n    = 1'b1;
    clock_locked = 1'b0;
    soft_rst_req = 1'b0;
    stage_ack    = 3'b000;
    #1 sys_rst_n = 1'b0;
    #1;
    check_val("rst_stage_rst", stage_rst, 3'b111);
    check_val("rst_all_ready", all_ready, 0);
    check_val("rst_seq_fault", seq_fault, 0);
    check_val("rst_retry", retry_cnt, 0);
    check_val("rst_state", debug_state, 0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    repeat (3) tick();
    check_val("idle_no_lock_state", debug_state, 0);
    check_val("idle_no_lock_rst", stage_rst, 3'b111);

    // Nominal bring-up
    clock_locked = 1'b1;
    seq_nominal(12, "nominal");

    // Lock loss in RUN, then a lock glitch during the stable window
    clock_locked = 1'b0;
    repeat (3) tick();
    check_val("lockloss_state", debug_state, 0);
    check_val("lockloss_rst", stage_rst, 3'b111);
    check_val("lockloss_ready", all_ready, 0);
    check_val("lockloss_retry", retry_cnt, 0);
    stage_ack = 3'b000;
    clock_locked = 1'b1;
    repeat (6) tick();
    clock_locked = 1'b0;
    repeat (2) tick();
    check_val("glitch_in_stable", debug_state, 1);
    clock_locked = 1'b1;
    tick();
    check_val("glitch_abort", debug_state, 0);
    seq_nominal(11, "glitch");

    // Soft reset from RUN, then two stage-1 ack timeouts into FAULT
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    stage_ack = 3'b000;
    check_val("soft_state", debug_state, 6);
    check_val("soft_rst", stage_rst, 3'b111);
    check_val("soft_ready", all_ready, 0);
    wait_rst(3'b110, n);
    check_val("soft_rel0_lat", n, 14);
    repeat (3) tick();
    stage_ack = 3'b001;
    wait_rst(3'b100, n);
    check_val("tmo1_rel1_lat", n, 6);
    wait_rst(3'b111, n);
    check_val("tmo1_lat", n, 20);
    check_val("tmo1_retry", retry_cnt, 1);
    check_val("tmo1_state", debug_state, 6);
    stage_ack = 3'b000;
    repeat (4) tick();
    check_val("tmo1_hold_exit", debug_state, 0);
    wait_rst(3'b110, n);
    check_val("tmo2_rel0_lat", n, 10);
    repeat (3) tick();
    stage_ack = 3'b001;
    wait_rst(3'b100, n);
    check_val("tmo2_rel1_lat", n, 6);
    wait_rst(3'b111, n);
    check_val("tmo2_lat", n, 20);
    check_val("tmo2_retry", retry_cnt, 2);
    check_val("tmo2_fault", seq_fault, 1);
    check_val("tmo2_state", debug_state, 7);
    stage_ack = 3'b000;

    // FAULT is sticky until soft reset
    repeat (5) tick();
    check_val("fault_sticky_state", debug_state, 7);
    check_val("fault_sticky_flag", seq_fault, 1);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check_val("fault_exit_state", debug_state, 6);
    check_val("fault_exit_flag", seq_fault, 0);
    check_val("fault_exit_retry", retry_cnt, 0);
    repeat (4) tick();
    check_val("fault_exit_hold_done", debug_state, 0);
    seq_nominal(10, "fault_exit");

    // Ack drop in RUN is a failure
    stage_ack = 3'b011;
    tick();
    check_val("ackdrop_rst", stage_rst, 3'b111);
    check_val("ackdrop_ready", all_ready, 0);
    check_val("ackdrop_retry", retry_cnt, 1);
    check_val("ackdrop_state", debug_state, 6);

    // Lock loss seen on the same edge as soft_rst_req wins
    clock_locked = 1'b0;
    stage_ack = 3'b000;
    repeat (2) tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check_val("lock_vs_soft_state", debug_state, 0);
    check_val("lock_vs_soft_retry", retry_cnt, 1);
    check_val("lock_vs_soft_rst", stage_rst, 3'b111);

    // Async reset while in DELAY
    clock_locked = 1'b1;
    wait_rst(3'b110, n);
    check_val("arst_rel0_lat", n, 12);
    repeat (3) tick();
    stage_ack = 3'b001;
    tick();
    tick();
    check_val("arst_in_delay", debug_state, 4);
    check_val("arst_pre_retry", retry_cnt, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check_val("arst_rst", stage_rst, 3'b111);
    check_val("arst_state", debug_state, 0);
    check_val("arst_retry", retry_cnt, 0);
    check_val("arst_ready", all_ready, 0);
    stage_ack = 3'b000;
    #2 sys_rst_n = 1'b1;
    check_val("arst_post_state", debug_state, 0);
    check_val("arst_post_retry", retry_cnt, 0);
    seq_nominal(12, "post_arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
